// File: rtl/decoder_scan_ctrl.sv
// decoder_scan_ctrl: round-robin scan driver for a 2-to-4 decoder.
// Produces the decoder select pair (sel_a = MSB, sel_b = LSB) and an active-low
// enable. Each channel is enabled for DWELL_CYC cycles, separated by BLANK_CYC
// cycles with the decoder disabled. Supports free-run and single-step modes.
// Optional feature: define SCAN_MASK_EN to add skip_mask[3:0] (bit i = 1 skips
// channel i). Without the macro all four channels are visited in order.
module decoder_scan_ctrl #(
    parameter int unsigned CNT_W     = 8,
    parameter int unsigned DWELL_CYC = 8,
    parameter int unsigned BLANK_CYC = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       stop,
    input  logic       step_mode,
    input  logic       step,
`ifdef SCAN_MASK_EN
    input  logic [3:0] skip_mask,
`endif
    output logic       sel_a,
    output logic       sel_b,
    output logic       en_n,
    output logic       busy,
    output logic       frame_done
);

    localparam int unsigned SEL_W = 2;

    // Terminal counts. DWELL counts 0..DWELL_CYC-1. BLANK counts up to BLANK_CYC;
    // it is entered at 1 from a dwell (that edge already blanks) and at 0 from
    // IDLE, so the first blank after start is one cycle longer.
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYC - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BLANK = 2'd1,
        S_DWELL = 2'd2,
        S_WAIT  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic               en_n_q, en_n_d;
    logic               busy_q, busy_d;
    logic               fd_q, fd_d;

    // Channel selection helpers
    logic               start_ok;
    logic [SEL_W-1:0]   start_sel;
    logic               adv_valid;
    logic [SEL_W-1:0]   adv_sel;
    logic               adv_wrap;
    logic               do_adv;

`ifdef SCAN_MASK_EN
    // Returns {found, index} of the first unmasked channel after cur, wrapping;
    // cur itself is checked last.
    function automatic logic [SEL_W:0] next_chan(input logic [SEL_W-1:0] cur,
                                                 input logic [3:0]       mask);
        logic [SEL_W:0]   res;
        logic [SEL_W-1:0] cand;
        res = '0;
        for (int i = 4; i >= 1; i--) begin
            cand = cur + SEL_W'(i);
            if (!mask[cand]) begin
                res = {1'b1, cand};
            end
        end
        return res;
    endfunction

    logic [SEL_W:0] first_pick;
    logic [SEL_W:0] next_pick;

    // Masked channel selection for start and advance
    always_comb begin
        first_pick = next_chan(SEL_W'(3), skip_mask);
        next_pick  = next_chan(sel_q, skip_mask);
        start_ok   = first_pick[SEL_W];
        start_sel  = first_pick[SEL_W-1:0];
        adv_valid  = next_pick[SEL_W];
        adv_sel    = next_pick[SEL_W-1:0];
        adv_wrap   = (next_pick[SEL_W-1:0] <= sel_q);
    end
`else
    // Plain modulo-4 channel selection
    always_comb begin
        start_ok  = 1'b1;
        start_sel = '0;
        adv_valid = 1'b1;
        adv_sel   = sel_q + SEL_W'(1);
        adv_wrap  = (sel_q == SEL_W'(3));
    end
`endif

    // Next-state and registered-output logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        en_n_d  = en_n_q;
        fd_d    = 1'b0;
        do_adv  = 1'b0;

        case (state_q)
            S_IDLE: begin
                en_n_d = 1'b1;
                sel_d  = '0;
                cnt_d  = '0;
                if (start && !stop && start_ok) begin
                    state_d = S_BLANK;
                    sel_d   = start_sel;
                end
            end
            S_BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    state_d = S_DWELL;
                    cnt_d   = '0;
                    en_n_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DWELL: begin
                if (cnt_q == DWELL_LAST) begin
                    if (step_mode) begin
                        state_d = S_WAIT;
                    end else begin
                        do_adv = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WAIT: begin
                if (step) begin
                    do_adv = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                sel_d   = '0;
                en_n_d  = 1'b1;
                cnt_d   = '0;
            end
        endcase

        // Select only changes on the edge that also disables the decoder
        if (do_adv) begin
            en_n_d = 1'b1;
            if (adv_valid) begin
                state_d = S_BLANK;
                sel_d   = adv_sel;
                cnt_d   = CNT_W'(1);
                fd_d    = adv_wrap;
            end else begin
                state_d = S_IDLE;
                sel_d   = '0;
                cnt_d   = '0;
            end
        end

        // stop overrides everything else
        if (stop && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            sel_d   = '0;
            en_n_d  = 1'b1;
            cnt_d   = '0;
            fd_d    = 1'b0;
        end

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            sel_q   <= '0;
            en_n_q  <= 1'b1;
            busy_q  <= 1'b0;
            fd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            en_n_q  <= en_n_d;
            busy_q  <= busy_d;
            fd_q    <= fd_d;
        end
    end

    assign sel_a      = sel_q[1];
    assign sel_b      = sel_q[0];
    assign en_n       = en_n_q;
    assign busy       = busy_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// Scoreboard bench for decoder_scan_ctrl: stimulus pushes expected outputs,
// a negedge monitor pops and compares them.
module tb_decoder_scan_ctrl;

    localparam int unsigned DW = 8;
    localparam int unsigned BL = 2;

    typedef struct packed {
        int unsigned tag;
        int unsigned cyc;
        logic [1:0]  sel;
        logic        en_n;
        logic        busy;
        logic        fd;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, start, stop, step_mode, step;
    logic sel_a, sel_b, en_n, busy, frame_done;
    logic start_m, stop_m, step_mode_m, step_m;
    logic sel_a_m, sel_b_m, en_n_m, busy_m, frame_done_m;
`ifdef SCAN_MASK_EN
    logic [3:0] skip_mask;
    logic [3:0] skip_mask_m;
`endif

    decoder_scan_ctrl #(.CNT_W(8), .DWELL_CYC(DW), .BLANK_CYC(BL)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .step_mode(step_mode), .step(step),
`ifdef SCAN_MASK_EN
        .skip_mask(skip_mask),
`endif
        .sel_a(sel_a), .sel_b(sel_b), .en_n(en_n), .busy(busy),
        .frame_done(frame_done)
    );

    decoder_scan_ctrl #(.CNT_W(8), .DWELL_CYC(1), .BLANK_CYC(1)) u_min (
        .clk(clk), .rst_n(rst_n), .start(start_m), .stop(stop_m),
        .step_mode(step_mode_m), .step(step_m),
`ifdef SCAN_MASK_EN
        .skip_mask(skip_mask_m),
`endif
        .sel_a(sel_a_m), .sel_b(sel_b_m), .en_n(en_n_m), .busy(busy_m),
        .frame_done(frame_done_m)
    );

    exp_t q0[$];
    exp_t q1[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    logic [1:0] prev_sel0 = 2'd0;
    logic [1:0] prev_sel1 = 2'd0;

    function automatic exp_t mk(input int unsigned tag, input int unsigned cyc,
                                input logic [1:0] s, input logic e,
                                input logic b, input logic f);
        exp_t r;
        r.tag = tag; r.cyc = cyc; r.sel = s; r.en_n = e; r.busy = b; r.fd = f;
        return r;
    endfunction

    // Free-run timeline: start at edge 0, first enable at edge 1+b,
    // then period b+d per channel; wrap 3->0 raises frame_done.
    function automatic exp_t free_exp(input int unsigned tag, input int n,
                                      input int d, input int b);
        exp_t r;
        int m, ch, p;
        r = mk(tag, n, 2'd0, 1'b1, 1'b1, 1'b0);
        m = n - (1 + b);
        if (m >= 0) begin
            ch = (m / (b + d)) % 4;
            p  = m % (b + d);
            if (p < d) begin
                r.sel  = 2'(ch);
                r.en_n = 1'b0;
            end else begin
                r.sel  = 2'((ch + 1) % 4);
                r.fd   = (p == d) && (ch == 3);
            end
        end
        return r;
    endfunction

    task automatic check(input string nm, input exp_t e, input logic [1:0] s,
                         input logic en, input logic b, input logic f);
        n_cmp++;
        if ({s, en, b, f} !== {e.sel, e.en_n, e.busy, e.fd}) begin
            n_fail++;
            $display("FAIL %s test%0d edge%0d: got sel=%0d en_n=%b busy=%b frame_done=%b, want sel=%0d en_n=%b busy=%b frame_done=%b",
                     nm, e.tag, e.cyc, s, en, b, f, e.sel, e.en_n, e.busy, e.fd);
        end
    endtask

    // Monitor: pop and compare, and check select never moves while enabled
    always @(negedge clk) begin
        exp_t e;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            check("dut", e, {sel_a, sel_b}, en_n, busy, frame_done);
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            check("min", e, {sel_a_m, sel_b_m}, en_n_m, busy_m, frame_done_m);
        end
        if ({sel_a, sel_b} != prev_sel0) begin
            n_cmp++;
            if (en_n !== 1'b1) begin
                n_fail++;
                $display("FAIL dut sel_change: sel %0d->%0d with en_n=%b, want en_n=1",
                         prev_sel0, {sel_a, sel_b}, en_n);
            end
        end
        if ({sel_a_m, sel_b_m} != prev_sel1) begin
            n_cmp++;
            if (en_n_m !== 1'b1) begin
                n_fail++;
                $display("FAIL min sel_change: sel %0d->%0d with en_n=%b, want en_n=1",
                         prev_sel1, {sel_a_m, sel_b_m}, en_n_m);
            end
        end
        prev_sel0 = {sel_a, sel_b};
        prev_sel1 = {sel_a_m, sel_b_m};
    end

    task automatic tick0(input exp_t e);
        @(posedge clk); #1;
        q0.push_back(e);
    endtask

    task automatic tick1(input exp_t e);
        @(posedge clk); #1;
        q1.push_back(e);
    endtask

    task automatic stop_dut(input int unsigned tag);
        stop = 1'b1;
        tick0(mk(tag, 999, 2'd0, 1'b1, 1'b0, 1'b0));
        stop = 1'b0;
    endtask

    initial begin
        #100000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; step_mode = 1'b0; step = 1'b0;
        start_m = 1'b0; stop_m = 1'b0; step_mode_m = 1'b0; step_m = 1'b0;
`ifdef SCAN_MASK_EN
        skip_mask = 4'b0000; skip_mask_m = 4'b0000;
`endif
        // Reset values on both instances
        repeat (2) begin
            @(posedge clk); #1;
            q0.push_back(mk(0, 0, 2'd0, 1'b1, 1'b0, 1'b0));
            q1.push_back(mk(0, 0, 2'd0, 1'b1, 1'b0, 1'b0));
        end
        rst_n = 1'b1;
        tick0(mk(0, 1, 2'd0, 1'b1, 1'b0, 1'b0));

        // Free-run over more than one frame
        start = 1'b1;
        tick0(free_exp(2, 0, DW, BL));
        start = 1'b0;
        for (int n = 1; n <= 60; n++) tick0(free_exp(2, n, DW, BL));
        stop_dut(2);

        // Restart ignored while busy; stop beats start/step mid-dwell on channel 1
        start = 1'b1;
        tick0(free_exp(4, 0, DW, BL));
        start = 1'b0;
        for (int n = 1; n <= 15; n++) begin
            start = (n == 5);
            tick0(free_exp(4, n, DW, BL));
        end
        start = 1'b1; stop = 1'b1; step = 1'b1;
        tick0(mk(4, 16, 2'd0, 1'b1, 1'b0, 1'b0));
        step = 1'b0;
        tick0(mk(4, 17, 2'd0, 1'b1, 1'b0, 1'b0));
        start = 1'b0; stop = 1'b0;
        tick0(mk(4, 18, 2'd0, 1'b1, 1'b0, 1'b0));

        // Step mode: hold channel 0, ignore early step, advance on step
        step_mode = 1'b1;
        start = 1'b1;
        tick0(free_exp(3, 0, DW, BL));
        start = 1'b0;
        for (int n = 1; n <= 60; n++) begin
            step = (n == 1);
            tick0(mk(3, n, 2'd0, (n < 3) ? 1'b1 : 1'b0, 1'b1, 1'b0));
        end
        step = 1'b1;
        tick0(mk(3, 61, 2'd1, 1'b1, 1'b1, 1'b0));
        step = 1'b0;
        tick0(mk(3, 62, 2'd1, 1'b1, 1'b1, 1'b0));
        for (int n = 63; n <= 80; n++) begin
            step_mode = !(n == 64 || n == 65);
            tick0(mk(3, n, 2'd1, 1'b0, 1'b1, 1'b0));
        end
        stop_dut(3);
        step_mode = 1'b0;

        // Async reset mid-dwell on channel 2
        start = 1'b1;
        tick0(free_exp(1, 0, DW, BL));
        start = 1'b0;
        for (int n = 1; n <= 25; n++) tick0(free_exp(1, n, DW, BL));
        @(posedge clk); #2;
        rst_n = 1'b0;
        q0.push_back(mk(1, 26, 2'd0, 1'b1, 1'b0, 1'b0));
        tick0(mk(1, 27, 2'd0, 1'b1, 1'b0, 1'b0));
        rst_n = 1'b1;
        tick0(mk(1, 28, 2'd0, 1'b1, 1'b0, 1'b0));

`ifdef SCAN_MASK_EN
        // Mask 0101: visit 1,3,1,3 with frame_done on each 3->1
        skip_mask = 4'b0101;
        start = 1'b1;
        tick0(mk(5, 0, 2'd1, 1'b1, 1'b1, 1'b0));
        start = 1'b0;
        for (int n = 1; n <= 45; n++) begin
            int m, ch, p;
            exp_t e;
            e = mk(5, n, 2'd1, 1'b1, 1'b1, 1'b0);
            m = n - 3;
            if (m >= 0) begin
                ch = ((m / 10) % 2 == 1) ? 3 : 1;
                p  = m % 10;
                if (p < 8) begin
                    e.sel = 2'(ch); e.en_n = 1'b0;
                end else begin
                    e.sel = (ch == 1) ? 2'd3 : 2'd1;
                    e.fd  = (ch == 3) && (p == 8);
                end
            end
            tick0(e);
        end
        stop_dut(5);
        skip_mask = 4'b1111;
        start = 1'b1;
        tick0(mk(5, 100, 2'd0, 1'b1, 1'b0, 1'b0));
        start = 1'b0;
        tick0(mk(5, 101, 2'd0, 1'b1, 1'b0, 1'b0));
        skip_mask = 4'b0000;
`endif

        // Minimum timing instance: DWELL_CYC=1, BLANK_CYC=1
        start_m = 1'b1;
        tick1(free_exp(6, 0, 1, 1));
        start_m = 1'b0;
        for (int n = 1; n <= 30; n++) tick1(free_exp(6, n, 1, 1));
        stop_m = 1'b1;
        tick1(mk(6, 999, 2'd0, 1'b1, 1'b0, 1'b0));
        stop_m = 1'b0;

        repeat (2) begin
            @(posedge clk); #1;
        end
        n_cmp++;
        if (q0.size() != 0 || q1.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d/%0d pending expectations, want 0/0",
                     q0.size(), q1.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
